// File: rtl/mlaccel_seq_fetch.sv
// mlaccel_seq_fetch: instruction fetch and control-flow sequencer.
// Fetches 32-bit words over the smem read port. It resolves jump, call/return,
// halt and (optionally) counted loops locally. All other words go through a
// prefetch FIFO to the compute unit.
//
// Build option: define MLACCEL_SEQ_LOOP_EN to execute LOOPSET/LOOPJMP locally
// with a 16-bit loop counter. Without it, opcodes 0x04/0x05 are forwarded to
// compute like any other instruction.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | waiting for start
// S_REQ   | issue a read of pc once the FIFO has room
// S_WAIT  | read outstanding, hold request until smem_ready, then decode
// S_DRAIN | program halted, wait for the FIFO to empty
// S_ABORT | stopped with a read in flight, hold request and discard the data

module mlaccel_seq_fetch #(
  parameter int FIFO_DEPTH  = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] addr,
  output logic        busy,
  output logic        fault,
  output logic        smem_valid,
  input  logic        smem_ready,
  output logic [15:0] smem_addr,
  input  logic [31:0] smem_data,
  output logic        comp_valid,
  input  logic        comp_ready,
  output logic [31:0] comp_insn
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int SIDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(STACK_DEPTH);

  localparam logic [7:0] OP_HALT    = 8'h00;
  localparam logic [7:0] OP_JUMP    = 8'h01;
  localparam logic [7:0] OP_CALL    = 8'h02;
  localparam logic [7:0] OP_RET     = 8'h03;
`ifdef MLACCEL_SEQ_LOOP_EN
  localparam logic [7:0] OP_LOOPSET = 8'h04;
  localparam logic [7:0] OP_LOOPJMP = 8'h05;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_m1;
  logic [15:0] stack_mem [0:STACK_DEPTH-1];

  logic [31:0] fifo_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic fifo_push, fifo_pop;

  logic start_ok;
  logic rd_take;

  logic [7:0]  opcode;
  logic [15:0] imm;
  logic [15:0] dec_pc;
  logic dec_halt, dec_enq, dec_push, dec_pop, dec_fault;

`ifdef MLACCEL_SEQ_LOOP_EN
  logic [15:0] lcnt;
  logic dec_lset, dec_ldec;
`endif

  assign opcode   = smem_data[7:0];
  assign imm      = smem_data[31:16];
  assign pc_inc   = pc + 16'd1;
  assign sp_m1    = sp - SP_W'(1);
  assign start_ok = (state == S_IDLE) && start && !stop;

  assign comp_valid = (fifo_cnt != '0);
  assign comp_insn  = comp_valid ? fifo_mem[rd_ptr] : '0;
  assign fifo_pop   = comp_valid && comp_ready;
  assign fifo_push  = rd_take && dec_enq;
  assign smem_addr  = pc;
  assign busy       = (state != S_IDLE) || comp_valid;

  // Decode the returned word into its control-flow effect
  always_comb begin
    dec_pc    = pc_inc;
    dec_halt  = 1'b0;
    dec_enq   = 1'b0;
    dec_push  = 1'b0;
    dec_pop   = 1'b0;
    dec_fault = 1'b0;
`ifdef MLACCEL_SEQ_LOOP_EN
    dec_lset  = 1'b0;
    dec_ldec  = 1'b0;
`endif
    case (opcode)
      OP_HALT: begin
        dec_halt = 1'b1;
        dec_pc   = pc;
      end
      OP_JUMP: dec_pc = imm;
      OP_CALL: begin
        if (sp == SP_FULL) begin
          // overflow: no push, no jump, stop the program
          dec_fault = 1'b1;
          dec_halt  = 1'b1;
          dec_pc    = pc;
        end else begin
          dec_push = 1'b1;
          dec_pc   = imm;
        end
      end
      OP_RET: begin
        if (sp == '0) begin
          dec_halt = 1'b1;
          dec_pc   = pc;
        end else begin
          dec_pop = 1'b1;
          dec_pc  = stack_mem[sp_m1[SIDX_W-1:0]];
        end
      end
`ifdef MLACCEL_SEQ_LOOP_EN
      OP_LOOPSET: dec_lset = 1'b1;
      OP_LOOPJMP: begin
        if (lcnt != 16'd0) begin
          dec_ldec = 1'b1;
          dec_pc   = imm;
        end
      end
`endif
      default: dec_enq = 1'b1;
    endcase
  end

  // Next-state and read-port control
  always_comb begin
    state_nxt  = state;
    smem_valid = 1'b0;
    rd_take    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (fifo_cnt != CNT_FULL) begin
          smem_valid = 1'b1;
          if (smem_ready) begin
            rd_take   = 1'b1;
            state_nxt = dec_halt ? S_DRAIN : S_REQ;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        smem_valid = 1'b1;
        if (smem_ready) begin
          rd_take   = 1'b1;
          state_nxt = dec_halt ? S_DRAIN : S_REQ;
        end
      end
      S_DRAIN: begin
        // leave as the last entry pops so busy drops right after it
        if ((fifo_cnt == '0) || ((fifo_cnt == CNT_ONE) && fifo_pop))
          state_nxt = S_IDLE;
      end
      S_ABORT: begin
        smem_valid = 1'b1;
        if (smem_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // a request already on the bus cannot be withdrawn, so stop parks in
    // ABORT until the arbiter answers it
    if (stop) begin
      rd_take   = 1'b0;
      state_nxt = (smem_valid && !smem_ready) ? S_ABORT : S_IDLE;
    end
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Program counter, call-stack pointer and sticky overflow flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc    <= '0;
      sp    <= '0;
      fault <= 1'b0;
    end else if (start_ok) begin
      pc    <= addr;
      sp    <= '0;
      fault <= 1'b0;
    end else if (rd_take) begin
      pc <= dec_pc;
      if (dec_push)     sp <= sp + SP_W'(1);
      else if (dec_pop) sp <= sp_m1;
      if (dec_fault) fault <= 1'b1;
    end
  end

  // Call-stack storage holds return addresses
  always_ff @(posedge clock) begin
    if (rd_take && dec_push) stack_mem[sp[SIDX_W-1:0]] <= pc_inc;
  end

`ifdef MLACCEL_SEQ_LOOP_EN
  // Loop counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                 lcnt <= '0;
    else if (start_ok)           lcnt <= '0;
    else if (rd_take && dec_lset) lcnt <= imm;
    else if (rd_take && dec_ldec) lcnt <= lcnt - 16'd1;
  end
`endif

  // FIFO pointers and occupancy, flushed on stop
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (stop) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (fifo_push && !fifo_pop)      fifo_cnt <= fifo_cnt + CNT_ONE;
      else if (!fifo_push && fifo_pop) fifo_cnt <= fifo_cnt - CNT_ONE;
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (fifo_push) fifo_mem[wr_ptr] <= smem_data;
  end

endmodule

// File: tb/tb_mlaccel_seq_fetch.sv
// Bench for mlaccel_seq_fetch: table of whole-program runs plus hand-written
// sequences for timing, backpressure, abort and reset corner cases.
module tb_mlaccel_seq_fetch;

  logic        clock, resetn, start, stop;
  logic [15:0] addr;
  logic        busy, fault, smem_valid, smem_ready;
  logic [15:0] smem_addr;
  logic [31:0] smem_data;
  logic        comp_valid, comp_ready;
  logic [31:0] comp_insn;

  mlaccel_seq_fetch #(.FIFO_DEPTH(4), .STACK_DEPTH(4)) dut (
    .clock(clock), .resetn(resetn), .start(start), .stop(stop), .addr(addr),
    .busy(busy), .fault(fault), .smem_valid(smem_valid), .smem_ready(smem_ready),
    .smem_addr(smem_addr), .smem_data(smem_data), .comp_valid(comp_valid),
    .comp_ready(comp_ready), .comp_insn(comp_insn)
  );

  typedef struct packed {
    logic [15:0]      addr;
    logic [7:0]       lat;
    logic [7:0]       exp_n;
    logic [3:0][31:0] exp_w;
    logic [7:0]       exp_reads;
    logic [15:0]      exp_last;
    logic             exp_fault;
  } vec_t;

  vec_t vecs [0:7];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int rd_count = 0;
  logic [15:0] rd_last = '0;
  int last_pop_cyc = 0;
  logic [31:0] got [$];
  logic [31:0] mem [0:65535];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // capture everything the compute side accepts
  always @(negedge clock) begin
    if (resetn === 1'b1 && comp_valid && comp_ready) begin
      got.push_back(comp_insn);
      last_pop_cyc = cyc;
    end
  end

  // memory/arbiter model: answers a held request after lat cycles
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    smem_ready = 1'b0;
    smem_data = '0;
    forever begin
      @(posedge clock); #1;
      smem_ready = 1'b0;
      if (smem_valid === 1'b1) begin
        if (wait_cnt >= lat) begin
          smem_ready = 1'b1;
          smem_data = mem[smem_addr];
          rd_count++;
          rd_last = smem_addr;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] a, output int s0);
    @(posedge clock); #2;
    start = 1'b1;
    addr = a;
    s0 = cyc;
    @(posedge clock); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic at_neg(input int n);
    do @(negedge clock); while (cyc < n);
  endtask

  task automatic at_pos(input int n);
    do begin @(posedge clock); #2; end while (cyc < n);
  endtask

  task automatic clear_logs();
    got.delete();
    rd_count = 0;
  endtask

  task automatic run_vec(input int i);
    int s0;
    bit ok;
    int n;
    lat = int'(vecs[i].lat);
    comp_ready = 1'b1;
    clear_logs();
    pulse_start(vecs[i].addr, s0);
    wait_idle(3000, ok);
    check($sformatf("v%0d_done", i), 32'(ok), 32'd1);
    n = int'(vecs[i].exp_n);
    check($sformatf("v%0d_count", i), got.size(), n);
    for (int k = 0; k < n; k++)
      check($sformatf("v%0d_word%0d", i, k),
            (k < got.size()) ? got[k] : 32'hDEAD_BEEF, vecs[i].exp_w[k]);
    check($sformatf("v%0d_reads", i), rd_count, 32'(vecs[i].exp_reads));
    check($sformatf("v%0d_last_addr", i), 32'(rd_last), 32'(vecs[i].exp_last));
    check($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int  s0;
    bit  ok;
    bit  stable;

    resetn = 1'b0; start = 1'b0; stop = 1'b0; addr = '0; comp_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = '0;

    // straight line
    mem[16'h0100] = 32'h10; mem[16'h0101] = 32'h11; mem[16'h0102] = 32'h12;
    // jump over a word
    mem[16'h0400] = 32'h0410_0001; mem[16'h0401] = 32'h99; mem[16'h0410] = 32'h41;
    // pc wrap
    mem[16'hFFFF] = 32'h77; mem[16'h0000] = 32'h78;
    // return on empty stack halts
    mem[16'h0500] = 32'h51; mem[16'h0501] = 32'h0000_0003;
    // call with a counted loop in the subroutine
    mem[16'h0300] = 32'h0200_0002; mem[16'h0301] = 32'h30;
    mem[16'h0200] = 32'h0002_0004; mem[16'h0201] = 32'h20;
    mem[16'h0202] = 32'h0201_0005; mem[16'h0203] = 32'h0000_0003;
    // five nested calls overflow a four-deep stack
    mem[16'h0600] = 32'h61;
    mem[16'h0601] = 32'h0602_0002; mem[16'h0602] = 32'h0603_0002;
    mem[16'h0603] = 32'h0604_0002; mem[16'h0604] = 32'h0605_0002;
    mem[16'h0605] = 32'h0606_0002; mem[16'h0606] = 32'h88;
    // eight plain words for backpressure / abort
    for (int i = 0; i < 8; i++) mem[16'h0700 + i] = 32'h70 + i;

    vecs[0] = '{16'h0100, 8'd1, 8'd3, {32'h0, 32'h12, 32'h11, 32'h10}, 8'd4, 16'h0103, 1'b0};
    vecs[1] = '{16'h0100, 8'd0, 8'd3, {32'h0, 32'h12, 32'h11, 32'h10}, 8'd4, 16'h0103, 1'b0};
    vecs[2] = '{16'h0400, 8'd2, 8'd1, {32'h0, 32'h0, 32'h0, 32'h41}, 8'd3, 16'h0411, 1'b0};
    vecs[3] = '{16'hFFFF, 8'd1, 8'd2, {32'h0, 32'h0, 32'h78, 32'h77}, 8'd3, 16'h0001, 1'b0};
    vecs[4] = '{16'h0500, 8'd0, 8'd1, {32'h0, 32'h0, 32'h0, 32'h51}, 8'd2, 16'h0501, 1'b0};
`ifdef MLACCEL_SEQ_LOOP_EN
    vecs[5] = '{16'h0300, 8'd1, 8'd4, {32'h30, 32'h20, 32'h20, 32'h20}, 8'd11, 16'h0302, 1'b0};
`else
    vecs[5] = '{16'h0300, 8'd1, 8'd4, {32'h30, 32'h0201_0005, 32'h20, 32'h0002_0004}, 8'd7, 16'h0302, 1'b0};
`endif
    vecs[6] = '{16'h0600, 8'd1, 8'd1, {32'h0, 32'h0, 32'h0, 32'h61}, 8'd6, 16'h0605, 1'b1};
    vecs[7] = '{16'h0100, 8'd3, 8'd3, {32'h0, 32'h12, 32'h11, 32'h10}, 8'd4, 16'h0103, 1'b0};

    repeat (3) @(negedge clock);
    check("reset_ctrl", {12'h0, busy, fault, smem_valid, comp_valid, smem_addr}, 32'h0);
    check("reset_insn", comp_insn, 32'h0);
    @(posedge clock); #2;
    resetn = 1'b1;

    // first request timing, then drain with the FIFO holding the whole program
    lat = 1;
    comp_ready = 1'b0;
    clear_logs();
    pulse_start(16'h0100, s0);
    at_neg(s0 + 1);
    check("first_req_valid", 32'(smem_valid), 32'd1);
    check("first_req_addr", 32'(smem_addr), 32'h0100);
    check("first_req_busy", 32'(busy), 32'd1);
    at_neg(s0 + 12);
    check("drain_reads", rd_count, 32'd4);
    check("drain_no_req", 32'(smem_valid), 32'd0);
    check("drain_head", comp_insn, 32'h10);
    @(posedge clock); #2;
    comp_ready = 1'b1;
    wait_idle(50, ok);
    check("drain_done", 32'(ok), 32'd1);
    check("busy_fall_delay", cyc - last_pop_cyc, 32'd1);
    check("drain_count", got.size(), 32'd3);
    repeat (2) @(negedge clock);

    for (int i = 0; i < 8; i++) run_vec(i);

    // backpressure: FIFO fills, fetch stops, head holds
    lat = 1;
    comp_ready = 1'b0;
    clear_logs();
    pulse_start(16'h0700, s0);
    stable = 1'b1;
    repeat (50) begin
      @(negedge clock);
      if (cyc >= s0 + 4 && comp_insn !== 32'h70) stable = 1'b0;
    end
    check("bp_reads", rd_count, 32'd4);
    check("bp_no_req", 32'(smem_valid), 32'd0);
    check("bp_valid", 32'(comp_valid), 32'd1);
    check("bp_head_stable", 32'(stable), 32'd1);
    @(posedge clock); #2;
    comp_ready = 1'b1;
    wait_idle(500, ok);
    check("bp_done", 32'(ok), 32'd1);
    check("bp_count", got.size(), 32'd8);
    for (int k = 0; k < 8; k++)
      check($sformatf("bp_word%0d", k), (k < got.size()) ? got[k] : 32'hDEAD_BEEF, 32'h70 + k);
    check("bp_total_reads", rd_count, 32'd9);
    repeat (2) @(negedge clock);

    // stop during WAIT, read answered three cycles later
    lat = 4;
    comp_ready = 1'b0;
    clear_logs();
    pulse_start(16'h0700, s0);
    at_pos(s0 + 7);
    stop = 1'b1;
    @(negedge clock);
    check("abort_cv_before", 32'(comp_valid), 32'd1);
    check("abort_req_before", 32'(smem_valid), 32'd1);
    @(posedge clock); #2;
    stop = 1'b0;
    at_neg(s0 + 8);
    check("abort_cv_after", 32'(comp_valid), 32'd0);
    check("abort_req_held", 32'(smem_valid), 32'd1);
    check("abort_addr_held", 32'(smem_addr), 32'h0701);
    at_neg(s0 + 10);
    check("abort_req_at_ready", 32'(smem_valid), 32'd1);
    at_neg(s0 + 11);
    check("abort_req_dropped", 32'(smem_valid), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_discard", 32'(comp_valid), 32'd0);
    check("abort_reads", rd_count, 32'd2);

    // start and stop together from IDLE
    lat = 1;
    comp_ready = 1'b1;
    clear_logs();
    @(posedge clock); #2;
    start = 1'b1; stop = 1'b1; addr = 16'h0100;
    @(posedge clock); #2;
    start = 1'b0; stop = 1'b0;
    @(negedge clock);
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_req", 32'(smem_valid), 32'd0);
    repeat (3) @(negedge clock);
    check("ss_reads", rd_count, 32'd0);

    // reset in the middle of a read
    lat = 1;
    comp_ready = 1'b0;
    clear_logs();
    pulse_start(16'h0100, s0);
    at_pos(s0 + 4);
    check("rst_pre_req", 32'(smem_valid), 32'd1);
    check("rst_pre_cv", 32'(comp_valid), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_ctrl", {12'h0, busy, fault, smem_valid, comp_valid, smem_addr}, 32'h0);
    check("rst_insn", comp_insn, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mlaccel_seq_fetch.md
# mlaccel_seq_fetch

Instruction fetch and control-flow sequencer between the command state machine and the compute unit. On `start` it fetches 32-bit instruction words from main memory through the arbiter's `smem` read port. It resolves sequencer-local control flow (jump, call/return, counted loop, halt) itself. All other words go through a prefetch FIFO to the compute unit's `comp` valid/ready port. `busy` feeds the global busy/status byte; `stop` aborts cleanly.

## Interface
- `FIFO_DEPTH`, 4: prefetch FIFO entries (power of two, 2..16).
- `STACK_DEPTH`, 4: call stack entries (1..8).
- `clock` in 1: sole clock, all logic on posedge.
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; begin execution at `addr`.
- `stop` in 1: one-cycle pulse; abort execution.
- `addr` in 16: start word address, sampled with `start`.
- `busy` out 1: execution in progress or FIFO non-empty.
- `fault` out 1: sticky; call-stack overflow occurred.
- `smem_valid` out 1: read request.
- `smem_ready` in 1: one-cycle pulse; `smem_data` valid this cycle.
- `smem_addr` out 16: request word address.
- `smem_data` in 32: read data.
- `comp_valid` out 1: instruction offered to compute.
- `comp_ready` in 1: compute accepts.
- `comp_insn` out 32: instruction word.

## Operation
- Opcode is `insn[7:0]`; immediate/target is `insn[31:16]`. Sequencer-local opcodes:
  - 0x00 HALT.
  - 0x01 JUMP: pc <= imm.
  - 0x02 CALL: push pc+1, then pc <= imm.
  - 0x03 RET: pop into pc; on an empty stack, acts as HALT.
  - 0x04 LOOPSET: lcnt <= imm.
  - 0x05 LOOPJMP: if lcnt != 0, then lcnt <= lcnt-1 and pc <= imm; else pc+1.
- All other opcodes are enqueued unchanged; pc <= pc+1.
- Local opcodes are never enqueued, so the FIFO never holds wrong-path words and no flush is needed except on stop.
- States:
  - IDLE: `start` loads pc=addr, clears stack, lcnt and `fault`, then goes to REQ.
  - REQ: if FIFO count + 1 <= FIFO_DEPTH, assert `smem_valid` with `smem_addr`=pc and go to WAIT.
  - WAIT: hold `smem_valid` and `smem_addr` until `smem_ready`, then decode `smem_data`. Go to REQ, or to DRAIN on HALT/RET-empty.
  - DRAIN: wait for FIFO empty, then go to IDLE.
  - ABORT: hold `smem_valid` until the pending `smem_ready`, discard the data, then go to IDLE.
- At most one outstanding read. `smem_valid` never drops before `smem_ready` (the arbiter cannot cancel an accepted read).
- `stop`:
  - Flushes the FIFO and drops `comp_valid` next cycle.
  - From WAIT, goes to ABORT; from any other state, goes to IDLE.
  - `stop` with `start` in the same cycle: stop wins and start is ignored.
- `start` while not IDLE: ignored.
- CALL with a full stack: set `fault` and treat as HALT (no push, no jump).
- pc and targets are 16-bit; pc+1 wraps 0xFFFF -> 0x0000.
- FIFO:
  - `comp_valid` = FIFO non-empty; `comp_insn` = head.
  - Pop on `comp_valid && comp_ready`.
  - Push and pop may occur in the same cycle, including when full.
  - Head stays stable while stalled.
- `busy` = (state != IDLE) || FIFO non-empty.

## Timing
- Reset values: all outputs 0; state IDLE; pc, lcnt, stack pointer and FIFO pointers 0.
- `start` at cycle 0 -> `smem_valid`=1, `smem_addr`=addr at cycle 1.
- `smem_ready` at cycle k:
  - Enqueued word: `comp_valid` at k+1.
  - Next `smem_valid` at k+1, with the resolved pc; this holds for local ops too.
- Throughput: one word per (arbiter latency + 1) cycles; local ops add zero extra cycles.
- `busy` rises at cycle 1 after `start` and falls one cycle after the last FIFO pop in DRAIN.
- `stop` at cycle s -> `comp_valid`=0 at s+1.

## Configuration
- `MLACCEL_SEQ_LOOP_EN` defined:
  - LOOPSET/LOOPJMP are executed locally as specified.
  - lcnt is a 16-bit register.
- `MLACCEL_SEQ_LOOP_EN` undefined:
  - No lcnt register.
  - Opcodes 0x04/0x05 are forwarded to compute as ordinary instructions.

## Test plan
- Straight line: start addr=0x0100, words 0x10,0x11,0x12,HALT at 0x0100..0x0103, `comp_ready`=1 -> compute receives 0x10,0x11,0x12 in order; `busy` falls after the third; no read beyond 0x0103.
- Backpressure: `comp_ready`=0 for 50 cycles, FIFO_DEPTH=4, 8 plain words -> exactly 4 reads complete, `smem_valid` stays low, `comp_insn` stable; release -> all 8 delivered without loss.
- Call/loop: CALL 0x0200; sub = LOOPSET 2, 0x20, LOOPJMP back, RET; then HALT -> compute sees 0x20 three times; pc returns to caller+1; `fault`=0 (with `MLACCEL_SEQ_LOOP_EN`).
- Overflow: STACK_DEPTH=4, 5 nested CALLs -> `fault`=1, `busy` falls, stack holds 4 entries; next `start` clears `fault`.
- Abort: `stop` while WAIT with `smem_ready` 3 cycles later -> `smem_valid` held until ready, data discarded, `comp_valid`=0 from the cycle after stop; `start`+`stop` in the same cycle from IDLE -> stays IDLE.
- Reset mid-run: `resetn` low during WAIT -> all outputs 0 immediately; a subsequent `start` runs normally.
